// File: rtl/pad_xbar_sequencer.sv
// ---------------------------------------------------------------------------
// pad_xbar_sequencer
//
// Purpose:
//   Sequenced, glitch-safe pad crossover for NChan pad channels. Each channel
//   connects its physical pad to source A (DIO side, sel=0) or to source B
//   (MIO side, sel=1). An accepted selector change runs break-before-make:
//     DRAIN  (SettleCycles) : pad OE forced low on the changing channels
//     SWITCH (1 cycle)      : committed selector takes the pending target
//     SETTLE (SettleCycles) : forcing held while the new driver settles
//   Channels that do not change pass through untouched for the whole sequence.
//
// Handshake:
//   A request is accepted in a cycle where sel_valid_i and sel_ready_o are
//   both high. sel_ready_o is high only in IDLE (and, with the lock option,
//   only while unlocked). A requester seeing ready low holds valid and target
//   stable until the accepting cycle.
//
// Configuration macro:
//   PAD_XBAR_LOCK_EN : adds lock_i and a sticky lock register. Once set (only
//                      reset clears it) no further requests are accepted; a
//                      sequence already running still completes.
//
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   sel_target_i/valid/ready   selector request handshake
//   sel_o                      committed selector (1 = B)
//   busy_o                     switch sequence in progress
//   done_o                     one-cycle pulse when a request completes
//   a_out_i/a_oe_i             source A output data / enable
//   b_out_i/b_oe_i             source B output data / enable
//   pad_out_o/pad_oe_o         to pad wrapper
//   pad_in_i/pad_in_raw_i      from pad wrapper
//   a_in_o/a_in_raw_o          pad inputs routed to source A
//   b_in_o/b_in_raw_o          pad inputs routed to source B
//   lock_i                     sticky lock request (PAD_XBAR_LOCK_EN only)
//   dbg_state_o                current FSM state, for observation only
// ---------------------------------------------------------------------------
module pad_xbar_sequencer #(
    parameter int unsigned      NChan        = 4,
    parameter int unsigned      SettleCycles = 4,
    parameter logic [NChan-1:0] ResetSel     = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [NChan-1:0] sel_target_i,
    input  logic             sel_valid_i,
    output logic             sel_ready_o,
    output logic [NChan-1:0] sel_o,
    output logic             busy_o,
    output logic             done_o,
    input  logic [NChan-1:0] a_out_i,
    input  logic [NChan-1:0] a_oe_i,
    input  logic [NChan-1:0] b_out_i,
    input  logic [NChan-1:0] b_oe_i,
    output logic [NChan-1:0] pad_out_o,
    output logic [NChan-1:0] pad_oe_o,
    input  logic [NChan-1:0] pad_in_i,
    input  logic [NChan-1:0] pad_in_raw_i,
    output logic [NChan-1:0] a_in_o,
    output logic [NChan-1:0] a_in_raw_o,
    output logic [NChan-1:0] b_in_o,
    output logic [NChan-1:0] b_in_raw_o,
`ifdef PAD_XBAR_LOCK_EN
    input  logic             lock_i,
`endif
    output logic [1:0]       dbg_state_o
);

    localparam int unsigned     CW       = $clog2(SettleCycles + 1);
    localparam logic [CW-1:0]   CNT_LOAD = CW'(SettleCycles - 1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_SWITCH = 2'd2,
        ST_SETTLE = 2'd3
    } state_t;

    state_t           r_state;
    logic [NChan-1:0] r_sel;
    logic [NChan-1:0] r_pend;
    logic [NChan-1:0] r_chg;
    logic [CW-1:0]    r_cnt;
    logic             r_done;

    state_t           w_state_nxt;
    logic [NChan-1:0] w_sel_nxt;
    logic [NChan-1:0] w_pend_nxt;
    logic [NChan-1:0] w_chg_nxt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             w_done_nxt;
    logic             w_busy;
    logic             w_ready;
    logic             w_accept;
    logic             w_lock;
    logic [NChan-1:0] w_force;

    // ------------------------------------------------------------------
    // Optional sticky lock
    // ------------------------------------------------------------------
`ifdef PAD_XBAR_LOCK_EN
    logic r_lock;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_lock <= 1'b0;
        end else begin
            r_lock <= r_lock | lock_i;
        end
    end

    assign w_lock = r_lock;
`else
    assign w_lock = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_sel   <= ResetSel;
            r_pend  <= ResetSel;
            r_chg   <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_pend  <= w_pend_nxt;
            r_chg   <= w_chg_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_pend_nxt  = r_pend;
        w_chg_nxt   = r_chg;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        w_busy      = (r_state != ST_IDLE);
        w_ready     = (r_state == ST_IDLE) & ~w_lock;
        w_accept    = sel_valid_i & w_ready;

        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (sel_target_i == r_sel) begin
                        // Nothing to switch: acknowledge without a sequence.
                        w_done_nxt = 1'b1;
                    end else begin
                        w_pend_nxt  = sel_target_i;
                        w_chg_nxt   = sel_target_i ^ r_sel;
                        w_cnt_nxt   = CNT_LOAD;
                        w_state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_SWITCH;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end
            ST_SWITCH: begin
                w_sel_nxt   = r_pend;
                w_cnt_nxt   = CNT_LOAD;
                w_state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: zero-latency muxing; changing channels are blanked while
    // the sequence runs so neither side ever sees or drives the pad.
    // ------------------------------------------------------------------
    assign w_force = r_chg & {NChan{w_busy}};

    assign pad_out_o  = (r_sel & b_out_i) | (~r_sel & a_out_i);
    assign pad_oe_o   = ((r_sel & b_oe_i) | (~r_sel & a_oe_i)) & ~w_force;

    assign a_in_o     = pad_in_i     & ~r_sel & ~w_force;
    assign a_in_raw_o = pad_in_raw_i & ~r_sel & ~w_force;
    assign b_in_o     = pad_in_i     &  r_sel & ~w_force;
    assign b_in_raw_o = pad_in_raw_i &  r_sel & ~w_force;

    assign sel_ready_o = w_ready;
    assign sel_o       = r_sel;
    assign busy_o      = w_busy;
    assign done_o      = r_done;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_pad_xbar_sequencer.sv
module tb_pad_xbar_sequencer;

    localparam int              NCH  = 4;
    localparam int              S    = 4;
    localparam logic [NCH-1:0]  RSEL = 4'b0101;
    localparam int              EW   = NCH + 32;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------
    // DUT
    // ------------------------------------------------------------------
    logic [NCH-1:0] sel_target;
    logic           sel_valid;
    logic           sel_ready;
    logic [NCH-1:0] sel_o;
    logic           busy;
    logic           done;
    logic [NCH-1:0] a_out, a_oe, b_out, b_oe;
    logic [NCH-1:0] pad_out, pad_oe, pad_in, pad_in_raw;
    logic [NCH-1:0] a_in, a_in_raw, b_in, b_in_raw;
    logic [1:0]     dbg_state;
    logic           lock_i;

    pad_xbar_sequencer #(
        .NChan        (NCH),
        .SettleCycles (S),
        .ResetSel     (RSEL)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .sel_target_i (sel_target),
        .sel_valid_i  (sel_valid),
        .sel_ready_o  (sel_ready),
        .sel_o        (sel_o),
        .busy_o       (busy),
        .done_o       (done),
        .a_out_i      (a_out),
        .a_oe_i       (a_oe),
        .b_out_i      (b_out),
        .b_oe_i       (b_oe),
        .pad_out_o    (pad_out),
        .pad_oe_o     (pad_oe),
        .pad_in_i     (pad_in),
        .pad_in_raw_i (pad_in_raw),
        .a_in_o       (a_in),
        .a_in_raw_o   (a_in_raw),
        .b_in_o       (b_in),
        .b_in_raw_o   (b_in_raw),
`ifdef PAD_XBAR_LOCK_EN
        .lock_i       (lock_i),
`endif
        .dbg_state_o  (dbg_state)
    );

    // ------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------
    int n_cmp = 0;
    int n_bad = 0;

    // Each entry: {expected done cycle[31:0], expected committed selector}
    logic [EW-1:0] exp_q[$];

    // Reference model: a request accepted in cycle T with a real change
    // blanks the changing channels over T+1..T+2S+1, commits the new
    // selector from T+S+2, and completes at T+2S+2.
    logic [NCH-1:0] m_sel    = RSEL;
    logic [NCH-1:0] m_new    = RSEL;
    bit             m_active = 1'b0;
    int             m_t      = 0;
    bit             m_lock   = 1'b0;
    int             acc_cnt  = 0;
    bit             rand_data = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model + per-cycle output checks
    // ------------------------------------------------------------------
    always @(negedge clk) begin : model
        logic [NCH-1:0] sel_e, force_e, out_e, oe_e, ain_e, ainr_e, bin_e, binr_e;
        bit busy_e, ready_e;

        if (!rst_n) begin
            m_sel    = RSEL;
            m_new    = RSEL;
            m_active = 1'b0;
            m_lock   = 1'b0;
            exp_q.delete();
        end else if (m_active && cyc >= m_t + 2*S + 2) begin
            m_sel    = m_new;
            m_active = 1'b0;
        end

        busy_e  = m_active && (cyc >= m_t + 1) && (cyc <= m_t + 2*S + 1);
        sel_e   = (m_active && cyc >= m_t + S + 2) ? m_new : m_sel;
        force_e = busy_e ? (m_sel ^ m_new) : '0;
        ready_e = !busy_e && !m_lock;

        for (int i = 0; i < NCH; i++) begin
            out_e[i]  = sel_e[i] ? b_out[i] : a_out[i];
            oe_e[i]   = (sel_e[i] ? b_oe[i] : a_oe[i]) & ~force_e[i];
            ain_e[i]  = (!sel_e[i] && !force_e[i]) ? pad_in[i]     : 1'b0;
            ainr_e[i] = (!sel_e[i] && !force_e[i]) ? pad_in_raw[i] : 1'b0;
            bin_e[i]  = ( sel_e[i] && !force_e[i]) ? pad_in[i]     : 1'b0;
            binr_e[i] = ( sel_e[i] && !force_e[i]) ? pad_in_raw[i] : 1'b0;
        end

        chk("sel_o",      32'(sel_o),     32'(sel_e));
        chk("busy",       32'(busy),      32'(busy_e));
        chk("ready",      32'(sel_ready), 32'(ready_e));
        chk("dbg_active", 32'(dbg_state != 2'd0), 32'(busy_e));
        chk("pad_out",    32'(pad_out),   32'(out_e));
        chk("pad_oe",     32'(pad_oe),    32'(oe_e));
        chk("a_in",       32'(a_in),      32'(ain_e));
        chk("a_in_raw",   32'(a_in_raw),  32'(ainr_e));
        chk("b_in",       32'(b_in),      32'(bin_e));
        chk("b_in_raw",   32'(b_in_raw),  32'(binr_e));

        if (rst_n && sel_valid && ready_e) begin
            acc_cnt++;
            if (sel_target == m_sel) begin
                exp_q.push_back({32'(cyc + 1), sel_target});
            end else begin
                m_active = 1'b1;
                m_t      = cyc;
                m_new    = sel_target;
                exp_q.push_back({32'(cyc + 2*S + 2), sel_target});
            end
        end
`ifdef PAD_XBAR_LOCK_EN
        if (rst_n && lock_i) m_lock = 1'b1;
`endif
    end

    // ------------------------------------------------------------------
    // Completion monitor
    // ------------------------------------------------------------------
    always @(negedge clk) begin : monitor
        logic [EW-1:0] e;
        if (!rst_n) begin
            chk("done_in_reset", 32'(done), 32'd0);
        end else if (done) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL done_unexpected: got done=1 expected no completion (cycle %0d)", cyc);
            end else begin
                e = exp_q.pop_front();
                chk("done_cycle", 32'(cyc), e[EW-1:NCH]);
                chk("done_sel",   32'(sel_o), 32'(e[NCH-1:0]));
            end
        end else if (exp_q.size() > 0 && cyc > int'(exp_q[0][EW-1:NCH])) begin
            e = exp_q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL done_missing: got no done expected done at cycle %0d (now %0d)",
                     e[EW-1:NCH], cyc);
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_req(input logic [NCH-1:0] t);
        int start;
        int n;
        start      = acc_cnt;
        n          = 0;
        sel_target = t;
        sel_valid  = 1'b1;
        do begin
            tick();
            n++;
        end while (acc_cnt == start && n < 60);
        if (acc_cnt == start) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: got no accept expected accept of %0h", t);
        end
        sel_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || m_active) && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) begin
            n_cmp++;
            n_bad++;
            $display("FAIL idle_timeout: got %0d pending expected 0", exp_q.size());
        end
    endtask

    // Random pad-side data, refreshed each cycle when enabled
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_data) begin
                a_out      = NCH'($urandom);
                a_oe       = NCH'($urandom);
                b_out      = NCH'($urandom);
                b_oe       = NCH'($urandom);
                pad_in     = NCH'($urandom);
                pad_in_raw = NCH'($urandom);
            end
        end
    end

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        logic [NCH-1:0] t;

        rst_n      = 1'b0;
        sel_valid  = 1'b0;
        sel_target = '0;
        lock_i     = 1'b0;
        a_out      = 4'hF;
        b_out      = 4'h0;
        a_oe       = 4'hF;
        b_oe       = 4'hF;
        pad_in     = 4'hA;
        pad_in_raw = 4'h6;

        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Reset pass-through with fixed data
        chk("dir_sel",     32'(sel_o),     32'(4'b0101));
        chk("dir_pad_out", 32'(pad_out),   32'(4'b1010));
        chk("dir_pad_oe",  32'(pad_oe),    32'(4'hF));
        chk("dir_ready",   32'(sel_ready), 32'd1);

        // Single-channel switch, then a no-change request
        send_req(4'b0111);
        wait_idle();
        tick();
        send_req(4'b0111);
        wait_idle();

        // Request held through a running sequence (back-to-back)
        send_req(4'b1000);
        send_req(4'b0001);
        wait_idle();

        // Randomized traffic
        rand_data = 1'b1;
        for (int k = 0; k < 25; k++) begin
            t = ($urandom_range(0, 3) == 0) ? m_sel : NCH'($urandom);
            send_req(t);
            repeat ($urandom_range(0, 3)) tick();
        end
        wait_idle();

        // Reset in the middle of a sequence
        send_req(~m_sel);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_reset_sel", 32'(sel_o), 32'(RSEL));
        send_req(~m_sel);
        wait_idle();

`ifdef PAD_XBAR_LOCK_EN
        // Lock raised during SETTLE: sequence finishes, then requests blocked
        send_req(~m_sel);
        repeat (S + 2) tick();
        lock_i = 1'b1;
        tick();
        lock_i = 1'b0;
        wait_idle();
        sel_target = ~m_sel;
        sel_valid  = 1'b1;
        repeat (20) tick();
        sel_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        send_req(~m_sel);
        wait_idle();
`endif

        repeat (4) tick();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pad_xbar_sequencer.md
# pad_xbar_sequencer

Sequenced, glitch-safe pad crossover for NChan pad channels, used in the chip-level padring. Each channel connects its physical pad to either a dedicated source A (DIO side) or a muxed source B (MIO side). Selection changes are accepted through a valid/ready handshake. Each accepted change runs a break-before-make sequence: the pad output enable is held low while the selector changes, so a switch never drives both sources onto a pad at once and never glitches a driver.

## Interface
Parameters:
- NChan, 4, number of switchable pad channels (1..32).
- SettleCycles, 4, length of each of the drain and settle phases, in clk_i cycles (>= 1).
- ResetSel, '0 (NChan bits), selector value loaded at reset. A bit value of 1 selects B.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  reset, asynchronous assert, active-low.
- sel_target_i  input  NChan  requested selector (per channel: 0=A, 1=B).
- sel_valid_i  input  1  request valid.
- sel_ready_o  output  1  request accepted when both valid and ready are high.
- sel_o  output  NChan  current committed selector.
- busy_o  output  1  a switch sequence is in progress.
- done_o  output  1  one-cycle pulse when a request completes.
- a_out_i / a_oe_i  input  NChan  source-A output data and output enable.
- b_out_i / b_oe_i  input  NChan  source-B output data and output enable.
- pad_out_o / pad_oe_o  output  NChan  to the pad wrapper.
- pad_in_i / pad_in_raw_i  input  NChan  from the pad wrapper.
- a_in_o / a_in_raw_o  output  NChan  pad input routed to source A.
- b_in_o / b_in_raw_o  output  NChan  pad input routed to source B.
- lock_i  input  1  present only with PAD_XBAR_LOCK_EN. Sticky lock request.

## Operation
- Registers:
  - sel_q (NChan bits)
  - pend_q (NChan bits, the target)
  - chg_q (NChan bits, the channels that change: pend_q XOR sel_q)
  - cnt_q ($clog2(SettleCycles+1) bits)
  - 2-bit FSM state
- FSM states:
  - IDLE: sel_ready_o=1.
    - On a handshake with sel_target_i==sel_o, stay in IDLE and pulse done_o the next cycle.
    - Otherwise latch pend_q and chg_q, load cnt_q=SettleCycles-1, and go to DRAIN.
  - DRAIN: pad_oe_o forced 0 on channels with chg_q=1. Decrement cnt_q. When cnt_q==0, go to SWITCH.
  - SWITCH: one cycle. sel_q<=pend_q, cnt_q<=SettleCycles-1, go to SETTLE. Forcing stays active.
  - SETTLE: forcing stays active. Decrement cnt_q. When cnt_q==0, go to IDLE and pulse done_o in the cycle IDLE is entered.
- sel_ready_o=0 and busy_o=1 in DRAIN, SWITCH and SETTLE. Requests presented in these states are not accepted; the requester holds valid.
- Datapath (combinational from sel_q and force):
  - pad_out_o = sel ? b_out_i : a_out_i.
  - pad_oe_o = (sel ? b_oe_i : a_oe_i) & ~force.
  - force = chg_q & busy.
- Input routing:
  - The selected side receives pad_in_i / pad_in_raw_i.
  - The unselected side receives 0.
  - During forcing, both sides of a changing channel receive 0.
- Channels with chg_q=0 pass through unaffected for the whole sequence.
- Reset:
  - sel_q=ResetSel, state IDLE, pend_q=ResetSel, chg_q=0, cnt_q=0.
  - Outputs during reset: sel_ready_o=1, busy_o=0, done_o=0, sel_o=ResetSel.
  - Pad outputs pass through per ResetSel.
- Reset asserted mid-sequence aborts the sequence immediately. sel_q returns to ResetSel and no done_o pulse is produced.

## Timing
- Request accepted in cycle T moves the FSM to DRAIN at T+1. The phases then run:
  - DRAIN: T+1..T+S
  - SWITCH: T+S+1
  - SETTLE: T+S+2..T+2S+1
  - IDLE with done_o=1: T+2S+2
- Here S=SettleCycles. busy_o is high for exactly 2S+1 cycles.
- sel_o changes at cycle T+S+2, the cycle after SWITCH.
- A no-change request accepted at T gives done_o=1 at T+1, with busy_o never asserted.
- Back-to-back: a new request can be accepted in the same cycle done_o pulses, because that cycle is IDLE.
- Pad data outputs have zero latency relative to their source inputs.

## Configuration
- PAD_XBAR_LOCK_EN defined:
  - Adds port lock_i and a register lock_q (reset 0).
  - lock_q is set when lock_i=1 and is cleared only by reset.
  - While lock_q=1, sel_ready_o=0.
  - A lock asserted mid-sequence lets that sequence complete, then blocks further requests.
- PAD_XBAR_LOCK_EN not defined:
  - No lock_i port and no lock_q register.
  - sel_ready_o depends only on the FSM state.

## Test plan
- Reset with ResetSel=4'b0101, then drive a_out_i=4'hF, b_out_i=0, a_oe_i=b_oe_i=4'hF -> sel_o=4'b0101, pad_out_o=4'b1010, pad_oe_o=4'hF, sel_ready_o=1.
- S=4, request 4'b0111 at T -> the sequence runs:
  - pad_oe_o[1]=0 from T+1 to T+9.
  - pad_oe_o of the other channels stays 1 throughout.
  - sel_o=4'b0111 at T+6.
  - done_o at T+10 only.
  - busy_o high for 9 cycles.
- Request equal to sel_o -> done_o at T+1, busy_o stays 0, pad_oe_o unchanged.
- Hold sel_valid_i during a sequence with a different target -> not accepted until the done_o cycle. The second sequence starts the following cycle.
- Assert rst_ni low at T+3 of a sequence -> sel_o=ResetSel and busy_o=0 immediately, no done_o pulse.
- With PAD_XBAR_LOCK_EN, pulse lock_i during SETTLE -> the sequence completes, then sel_ready_o=0 until reset and new requests are ignored.
